// File: rtl/store_buffer.sv
// -----------------------------------------------------------------------------
// store_buffer
//
// Posted-store buffer between a CPU and a single-ported data memory. Stores are
// queued in a circular FIFO and written to memory one at a time, at most one
// write every two cycles. Loads take priority over draining. A load whose
// address matches a pending store is stalled until that store has drained.
//
// Optional feature (macro STB_FORWARD_EN):
//   If the youngest pending store to the load address is a full word, the load
//   is answered from the buffer (ld_fwd_o / ld_fwd_data_o). Byte and halfword
//   matches still stall. With the macro undefined, forwarding outputs are 0.
//
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   st_valid_i, st_ready_o        store handshake (ready = not full)
//   st_addr_i, st_data_i          store word address and write data
//   st_byte_i, st_half_i          store size (neither = word, both = illegal)
//   ld_valid_i, ld_addr_i         load request and address
//   ld_stall_o                    CPU must hold the load this cycle
//   ld_fwd_o, ld_fwd_data_o       load answered from the buffer
//   mem_addr_o, mem_wdata_o       data memory address / write data
//   mem_write_o, mem_read_o       data memory strobes (never both high)
//   mem_byte_o, mem_half_o        data memory access size
//   count_o, empty_o              pending entry count, buffer empty
// -----------------------------------------------------------------------------
module store_buffer #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    // store port
    input  logic                       st_valid_i,
    output logic                       st_ready_o,
    input  logic [31:0]                st_addr_i,
    input  logic [31:0]                st_data_i,
    input  logic                       st_byte_i,
    input  logic                       st_half_i,
    // load port
    input  logic                       ld_valid_i,
    input  logic [31:0]                ld_addr_i,
    output logic                       ld_stall_o,
    output logic                       ld_fwd_o,
    output logic [31:0]                ld_fwd_data_o,
    // data memory
    output logic [31:0]                mem_addr_o,
    output logic [31:0]                mem_wdata_o,
    output logic                       mem_write_o,
    output logic                       mem_read_o,
    output logic                       mem_byte_o,
    output logic                       mem_half_o,
    // status
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       empty_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic [1:0] {
        StIdle,
        StDrain,
        StGap
    } state_e;

    // Entry storage
    logic [31:0]     addr_q  [DEPTH];
    logic [31:0]     data_q  [DEPTH];
    logic            byte_q  [DEPTH];
    logic            half_q  [DEPTH];
    logic            valid_q [DEPTH];

    logic [PtrW-1:0] head_q, tail_q;
    logic [CntW-1:0] count_q, count_d;
    state_e          state_q, state_d;

    // Registered memory write beat, loaded on entry to StDrain
    logic [31:0]     mem_addr_q, mem_wdata_q;
    logic            mem_byte_q, mem_half_q;

    logic            push, pop, load_mem;
    logic            in_drain;
    logic            match;
    logic            fwd;
    logic [31:0]     fwd_data;
    logic            drain_ok;

    assign in_drain   = (state_q == StDrain);
    assign st_ready_o = (count_q < CntW'(DEPTH));
    assign push       = st_valid_i & st_ready_o & ~(st_byte_i & st_half_i);

    // ------------------------------------------------------------------------
    // Address match; scanning oldest to youngest leaves the youngest match last
    // ------------------------------------------------------------------------
`ifdef STB_FORWARD_EN
    logic        yng_word;
    logic [31:0] yng_data;
`endif

    always_comb begin
        logic [PtrW-1:0] idx;
        match = 1'b0;
`ifdef STB_FORWARD_EN
        yng_word = 1'b0;
        yng_data = '0;
`endif
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = head_q + PtrW'(i);
            if (valid_q[idx] && (addr_q[idx] == ld_addr_i)) begin
                match = 1'b1;
`ifdef STB_FORWARD_EN
                yng_word = ~byte_q[idx] & ~half_q[idx];
                yng_data = data_q[idx];
`endif
            end
        end
    end

`ifdef STB_FORWARD_EN
    assign fwd      = ld_valid_i & match & yng_word & ~in_drain;
    assign fwd_data = fwd ? yng_data : '0;
`else
    assign fwd      = 1'b0;
    assign fwd_data = '0;
`endif

    assign ld_fwd_o      = fwd;
    assign ld_fwd_data_o = fwd_data;
    assign ld_stall_o    = ld_valid_i & (in_drain | (match & ~fwd));
    assign mem_read_o    = ld_valid_i & ~ld_stall_o & ~fwd;

    // A load only holds off draining when it is actually being served (memory
    // read or forward). A load stalled on a match must let the buffer drain,
    // otherwise it would wait forever on its own blocker.
    assign drain_ok = (count_q != '0) & ~(ld_valid_i & ~ld_stall_o);

    // ------------------------------------------------------------------------
    // Drain FSM
    // ------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        pop      = 1'b0;
        load_mem = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (drain_ok) begin
                    state_d  = StDrain;
                    load_mem = 1'b1;
                end
            end
            StDrain: begin
                state_d = StGap;
                pop     = 1'b1;
            end
            StGap: begin
                if (drain_ok) begin
                    state_d  = StDrain;
                    load_mem = 1'b1;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            count_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            if (pop) begin
                head_q <= head_q + PtrW'(1);
            end
            if (push) begin
                tail_q <= tail_q + PtrW'(1);
            end
        end
    end

    // Entry array; head and tail never coincide on a cycle with both push and
    // pop (that would require pushing while full), so the order is irrelevant.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                addr_q[i]  <= '0;
                data_q[i]  <= '0;
                byte_q[i]  <= 1'b0;
                half_q[i]  <= 1'b0;
                valid_q[i] <= 1'b0;
            end
        end else begin
            if (pop) begin
                valid_q[head_q] <= 1'b0;
            end
            if (push) begin
                addr_q[tail_q]  <= st_addr_i;
                data_q[tail_q]  <= st_data_i;
                byte_q[tail_q]  <= st_byte_i;
                half_q[tail_q]  <= st_half_i;
                valid_q[tail_q] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_byte_q  <= 1'b0;
            mem_half_q  <= 1'b0;
        end else if (load_mem) begin
            mem_addr_q  <= addr_q[head_q];
            mem_wdata_q <= data_q[head_q];
            mem_byte_q  <= byte_q[head_q];
            mem_half_q  <= half_q[head_q];
        end
    end

    // Outside StDrain the memory port belongs to the load path (word access).
    assign mem_write_o = in_drain;
    assign mem_addr_o  = in_drain ? mem_addr_q : ld_addr_i;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_byte_o  = in_drain & mem_byte_q;
    assign mem_half_o  = in_drain & mem_half_q;

    assign count_o = count_q;
    assign empty_o = (count_q == '0);

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        st_valid, st_ready, st_byte, st_half;
    logic [31:0] st_addr, st_data;
    logic        ld_valid, ld_stall, ld_fwd;
    logic [31:0] ld_addr, ld_fwd_data;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_write, mem_read, mem_byte, mem_half;
    logic [2:0]  count;
    logic        empty;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        b;
        logic        h;
    } st_t;

    st_t exp_q[$];

    always #5 clk = ~clk;

    store_buffer #(.DEPTH(4)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .st_valid_i    (st_valid),
        .st_ready_o    (st_ready),
        .st_addr_i     (st_addr),
        .st_data_i     (st_data),
        .st_byte_i     (st_byte),
        .st_half_i     (st_half),
        .ld_valid_i    (ld_valid),
        .ld_addr_i     (ld_addr),
        .ld_stall_o    (ld_stall),
        .ld_fwd_o      (ld_fwd),
        .ld_fwd_data_o (ld_fwd_data),
        .mem_addr_o    (mem_addr),
        .mem_wdata_o   (mem_wdata),
        .mem_write_o   (mem_write),
        .mem_read_o    (mem_read),
        .mem_byte_o    (mem_byte),
        .mem_half_o    (mem_half),
        .count_o       (count),
        .empty_o       (empty)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Drive one store for one cycle; exp_rdy is the bench's own view of whether
    // the buffer has room. Legal accepted stores go to the scoreboard.
    task automatic push(input logic [31:0] a, input logic [31:0] d,
                        input logic b, input logic h, input logic exp_rdy);
        st_t e;
        @(negedge clk);
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
        st_byte  = b;
        st_half  = h;
        #1;
        check_eq("st_ready", {31'b0, st_ready}, {31'b0, exp_rdy});
        if (exp_rdy && !(b && h)) begin
            e.addr = a;
            e.data = d;
            e.b    = b;
            e.h    = h;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        st_valid = 1'b0;
    endtask

    // Memory-side monitor: every write beat must match the oldest expected store
    always @(negedge clk) begin
        st_t e;
        #2;
        if (rst_n) begin
            check_eq("mem_mutex", {31'b0, mem_write & mem_read}, 32'd0);
            if (mem_write) begin
                if (exp_q.size() == 0) begin
                    check_eq("sb_underflow", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("wr_addr", mem_addr, e.addr);
                    check_eq("wr_data", mem_wdata, e.data);
                    check_eq("wr_size", {30'b0, mem_byte, mem_half}, {30'b0, e.b, e.h});
                end
            end
        end
    end

    initial begin
        rst_n    = 1'b0;
        st_valid = 1'b0;
        st_addr  = '0;
        st_data  = '0;
        st_byte  = 1'b0;
        st_half  = 1'b0;
        ld_valid = 1'b0;
        ld_addr  = '0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_count", {29'b0, count}, 32'd0);
        check_eq("rst_empty", {31'b0, empty}, 32'd1);
        check_eq("rst_ready", {31'b0, st_ready}, 32'd1);
        check_eq("rst_mem_write", {31'b0, mem_write}, 32'd0);
        check_eq("rst_mem_addr", mem_addr, 32'd0);
        check_eq("rst_mem_wdata", mem_wdata, 32'd0);
        check_eq("rst_fwd", {31'b0, ld_fwd}, 32'd0);
        check_eq("rst_fwd_data", ld_fwd_data, 32'd0);
        rst_n = 1'b1;

        // Single word store drains after one idle cycle, one write beat
        push(32'd3, 32'h5, 1'b0, 1'b0, 1'b1);
        @(negedge clk); #1;
        check_eq("one_count", {29'b0, count}, 32'd1);
        check_eq("one_no_write_yet", {31'b0, mem_write}, 32'd0);
        @(negedge clk); #1;
        check_eq("one_write", {31'b0, mem_write}, 32'd1);
        check_eq("one_addr", mem_addr, 32'd3);
        @(negedge clk); #1;
        check_eq("one_empty", {31'b0, empty}, 32'd1);
        check_eq("one_gap_write", {31'b0, mem_write}, 32'd0);

        // Fill while a load holds the memory port, then overflow
        @(negedge clk);
        ld_valid = 1'b1;
        ld_addr  = 32'd9;
        for (int i = 0; i < 4; i++) begin
            push(32'h10 + i, 32'hA0 + i, 1'b0, 1'b0, 1'b1);
            check_eq("fill_read", {31'b0, mem_read}, 32'd1);
            check_eq("fill_nowrite", {31'b0, mem_write}, 32'd0);
        end
        check_eq("full_ready", {31'b0, st_ready}, 32'd0);
        check_eq("full_count", {29'b0, count}, 32'd4);
        push(32'h14, 32'hA4, 1'b0, 1'b0, 1'b0);
        check_eq("drop_count", {29'b0, count}, 32'd4);
        check_eq("drop_read", {31'b0, mem_read}, 32'd1);
        @(negedge clk);
        ld_valid = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        check_eq("fill_drained", {31'b0, empty}, 32'd1);

        // Push on the same edge as a pop; tail wraps past the last slot
        @(negedge clk);
        ld_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push(32'h20 + i, 32'hB0 + i, 1'b0, 1'b0, 1'b1);
        end
        @(negedge clk);
        ld_valid = 1'b0;
        push(32'h23, 32'hB3, 1'b0, 1'b0, 1'b1);
        check_eq("pushpop_count", {29'b0, count}, 32'd3);
        check_eq("pushpop_gap", {31'b0, mem_write}, 32'd0);
        repeat (10) @(negedge clk);
        #1;
        check_eq("wrap_drained", {31'b0, empty}, 32'd1);

        // Byte+half together is illegal and never enters the buffer
        push(32'h30, 32'h99, 1'b1, 1'b1, 1'b1);
        check_eq("illegal_count", {29'b0, count}, 32'd0);
        repeat (3) @(negedge clk);

        // Load hitting a pending byte store stalls until it has drained
        @(negedge clk);
        ld_valid = 1'b1;
        ld_addr  = 32'd9;
        push(32'd7, 32'hAB, 1'b1, 1'b0, 1'b1);
        check_eq("byte_count", {29'b0, count}, 32'd1);
        @(negedge clk);
        ld_addr = 32'd7;
        #1;
        check_eq("byte_stall", {31'b0, ld_stall}, 32'd1);
        check_eq("byte_noread", {31'b0, mem_read}, 32'd0);
        check_eq("byte_nofwd", {31'b0, ld_fwd}, 32'd0);
        @(negedge clk); #1;
        check_eq("byte_drain_stall", {31'b0, ld_stall}, 32'd1);
        check_eq("byte_drain_write", {31'b0, mem_write}, 32'd1);
        check_eq("byte_drain_size", {31'b0, mem_byte}, 32'd1);
        @(negedge clk); #1;
        check_eq("byte_after_stall", {31'b0, ld_stall}, 32'd0);
        check_eq("byte_after_read", {31'b0, mem_read}, 32'd1);
        check_eq("byte_after_addr", mem_addr, 32'd7);
        check_eq("byte_after_size", {31'b0, mem_byte}, 32'd0);
        ld_valid = 1'b0;
        repeat (2) @(negedge clk);

        // Two word stores to one address, then a load of that address
        @(negedge clk);
        ld_valid = 1'b1;
        ld_addr  = 32'd9;
        push(32'd2, 32'h11, 1'b0, 1'b0, 1'b1);
        push(32'd2, 32'h22, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        ld_addr = 32'd2;
        #1;
`ifdef STB_FORWARD_EN
        check_eq("fwd_valid", {31'b0, ld_fwd}, 32'd1);
        check_eq("fwd_data", ld_fwd_data, 32'h22);
        check_eq("fwd_noread", {31'b0, mem_read}, 32'd0);
        check_eq("fwd_nostall", {31'b0, ld_stall}, 32'd0);
`else
        check_eq("nofwd_valid", {31'b0, ld_fwd}, 32'd0);
        check_eq("nofwd_data", ld_fwd_data, 32'd0);
        check_eq("nofwd_stall", {31'b0, ld_stall}, 32'd1);
        check_eq("nofwd_noread", {31'b0, mem_read}, 32'd0);
        repeat (4) @(negedge clk);
        #1;
        check_eq("nofwd_after_read", {31'b0, mem_read}, 32'd1);
        check_eq("nofwd_after_stall", {31'b0, ld_stall}, 32'd0);
`endif
        @(negedge clk);
        ld_valid = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        check_eq("fwd_drained", {31'b0, empty}, 32'd1);

        // Reset in the middle of a write beat
        @(negedge clk);
        ld_valid = 1'b1;
        ld_addr  = 32'd9;
        push(32'h40, 32'h1, 1'b0, 1'b0, 1'b1);
        push(32'h41, 32'h2, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        ld_valid = 1'b0;
        @(negedge clk);
        #3;
        check_eq("pre_rst_write", {31'b0, mem_write}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_write", {31'b0, mem_write}, 32'd0);
        check_eq("mid_rst_count", {29'b0, count}, 32'd0);
        check_eq("mid_rst_ready", {31'b0, st_ready}, 32'd1);
        check_eq("mid_rst_empty", {31'b0, empty}, 32'd1);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        push(32'h50, 32'h77, 1'b0, 1'b0, 1'b1);
        repeat (5) @(negedge clk);
        #1;
        check_eq("post_rst_drained", {31'b0, empty}, 32'd1);

        check_eq("sb_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
